// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for a 4-bit combinational ALU: register file, operand staging, result writeback.
// Optional zero/negative result flags are enabled by defining ALU_ISSUE_FLAGS_EN.
module alu_issue_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_s2,
  output logic              alu_s1,
  output logic              alu_s0,
  input  logic [DATA_W-1:0] alu_out,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  output logic [ADDR_W-1:0] result_rd,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);

  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic {
    S_IDLE,
    S_EXEC
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_rf [NREG];
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_rd;
  logic              r_result_valid;
  logic [DATA_W-1:0] r_result_data;
  logic [ADDR_W-1:0] r_result_rd;
  logic              w_ready;
  logic              w_accept;
  logic              w_wb;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (instr_valid) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready  = (r_state == S_IDLE);
    w_accept = w_ready && instr_valid;
    w_wb     = (r_state == S_EXEC);
  end

  // NOTE: the register file is small and must read 0 after reset, so it is reset explicitly.
  // Writeback is applied after the host load so it wins on an address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_wb && (r_rd == ADDR_W'(i)))         r_rf[i] <= alu_out;
        else if (ld_en && (ld_addr == ADDR_W'(i))) r_rf[i] <= ld_data;
      end
    end
  end

  // Operands are read from pre-edge register contents, so a same-edge load is not seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_a <= '0;
      r_alu_b <= '0;
      r_op    <= '0;
      r_rd    <= '0;
    end else if (w_accept) begin
      r_alu_a <= r_rf[instr_rs1];
      r_alu_b <= r_rf[instr_rs2];
      r_op    <= instr_op;
      r_rd    <= instr_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
      r_result_rd    <= '0;
    end else begin
      r_result_valid <= w_wb;
      if (w_wb) begin
        r_result_data <= alu_out;
        r_result_rd   <= r_rd;
      end
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  logic r_flag_z;
  logic r_flag_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
    end else if (w_wb) begin
      r_flag_z <= (alu_out == '0);
      r_flag_n <= alu_out[DATA_W-1];
    end
  end

  assign flag_z = r_flag_z;
  assign flag_n = r_flag_n;
`endif

  assign instr_ready  = w_ready;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_s2       = r_op[2];
  assign alu_s1       = r_op[1];
  assign alu_s0       = r_op[0];
  assign result_valid = r_result_valid;
  assign result_data  = r_result_data;
  assign result_rd    = r_result_rd;
  assign dbg_data     = r_rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: emulates the ALU, runs the directed plan, then random traffic
// against a transaction-level reference model. Define ALU_ISSUE_FLAGS_EN to also check the flags.
module tb_alu_issue_ctrl;

  localparam int DW = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] alu_a, alu_b;
  logic          alu_s2, alu_s1, alu_s0;
  logic [DW-1:0] alu_out;
  logic          result_valid;
  logic [DW-1:0] result_data;
  logic [AW-1:0] result_rd;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
`ifdef ALU_ISSUE_FLAGS_EN
  logic          flag_z, flag_n;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s2(alu_s2), .alu_s1(alu_s1), .alu_s0(alu_s0),
    .alu_out(alu_out),
    .result_valid(result_valid), .result_data(result_data), .result_rd(result_rd),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_ISSUE_FLAGS_EN
    , .flag_z(flag_z), .flag_n(flag_n)
`endif
  );

  // The external ALU: plain arithmetic, wrapped to DW bits.
  function automatic logic [DW-1:0] alu_fn(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int r;
    case (op)
      3'd0:       r = int'(a) & int'(b);
      3'd1:       r = int'(a) | int'(b);
      3'd2:       r = int'(a) ^ int'(b);
      3'd3:       r = 15 - int'(a);
      3'd4, 3'd6: r = int'(a) - int'(b) + 16;
      default:    r = int'(a) + int'(b);
    endcase
    return DW'(r % 16);
  endfunction

  assign alu_out = alu_fn({alu_s2, alu_s1, alu_s0}, alu_a, alu_b);

  // Reference model: one optional in-flight instruction plus the architectural state.
  logic [DW-1:0] m_rf [4];
  bit            m_busy;
  logic [2:0]    m_op;
  logic [DW-1:0] m_a, m_b;
  logic [AW-1:0] m_rd;
  bit            m_rv;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_rrd;
  bit            m_z, m_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_busy = 0; m_op = '0; m_a = '0; m_b = '0; m_rd = '0;
    m_rv = 0; m_rdata = '0; m_rrd = '0; m_z = 0; m_n = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ready"},  instr_ready,  !m_busy);
    check({tag, ".rvalid"}, result_valid, m_rv);
    check({tag, ".rdata"},  result_data,  m_rdata);
    check({tag, ".rrd"},    result_rd,    m_rrd);
    check({tag, ".alu_a"},  alu_a,        m_a);
    check({tag, ".alu_b"},  alu_b,        m_b);
    check({tag, ".op"},     {alu_s2, alu_s1, alu_s0}, m_op);
    check({tag, ".dbg"},    dbg_data,     m_rf[dbg_addr]);
`ifdef ALU_ISSUE_FLAGS_EN
    check({tag, ".flag_z"}, flag_z, m_z);
    check({tag, ".flag_n"}, flag_n, m_n);
`endif
  endtask

  // Advance one clock for both DUT and model, then compare everything.
  task automatic tick(input string tag);
    bit            acc;
    logic [DW-1:0] wbv;
    acc = !m_busy && instr_valid;
    @(posedge clk);
    #1;
    m_rv = 0;
    wbv  = '0;
    if (m_busy) begin
      wbv = alu_fn(m_op, m_a, m_b);
      m_rv = 1; m_rdata = wbv; m_rrd = m_rd;
      m_z = (wbv == 0); m_n = wbv[DW-1];
    end
    if (acc) begin
      m_a = m_rf[instr_rs1]; m_b = m_rf[instr_rs2]; m_op = instr_op;
    end
    if (ld_en) m_rf[ld_addr] = ld_data;
    if (m_busy) m_rf[m_rd] = wbv;
    if (acc) m_rd = instr_rd;
    m_busy = acc;
    check_all(tag);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    tick("load");
    ld_en = 0;
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [DW-1:0] exp);
    set_instr(op, rd, rs1, rs2);
    instr_valid = 1;
    tick("accept");
    instr_valid = 0;
    check("plan.busy_valid", result_valid, 1'b0);
    tick("wb");
    check("plan.valid", result_valid, 1'b1);
    check("plan.data", result_data, exp);
    check("plan.rd", result_rd, rd);
  endtask

  task automatic peek(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    dbg_addr = a;
    #1;
    check("plan.dbg", dbg_data, exp);
  endtask

  logic [DW-1:0] plan_b2b [5];

  initial begin
    reset = 1; instr_valid = 0; set_instr(3'd0, '0, '0, '0);
    ld_en = 0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    model_reset();
    #12;
    check_all("reset");
    for (int i = 0; i < 4; i++) peek(AW'(i), '0);
    reset = 0;

    // Basic AND into r2.
    load(2'd0, 4'b0110);
    load(2'd1, 4'b0011);
    issue(3'd0, 2'd2, 2'd0, 2'd1, 4'b0010);
    peek(2'd2, 4'b0010);

    // Back-to-back with instr_valid held: next instruction presented while in EXEC.
    plan_b2b = '{4'b0111, 4'b0101, 4'b1001, 4'b0011, 4'b1001};
    instr_valid = 1;
    for (int k = 0; k < 5; k++) begin
      set_instr(3'(k + 1), 2'd3, 2'd0, 2'd1);
      tick("b2b.accept");
      check("b2b.ready_low", instr_ready, 1'b0);
      if (k < 4) set_instr(3'(k + 2), 2'd3, 2'd0, 2'd1);
      tick("b2b.wb");
      check("b2b.data", result_data, plan_b2b[k]);
      check("b2b.valid", result_valid, 1'b1);
    end
    instr_valid = 0;
    tick("b2b.idle");

    // Wrap-around subtract, then add proving the new r0 is used.
    load(2'd0, 4'b0011);
    load(2'd1, 4'b0100);
    issue(3'd4, 2'd0, 2'd0, 2'd1, 4'b1111);
`ifdef ALU_ISSUE_FLAGS_EN
    check("plan.flag_n", flag_n, 1'b1);
`endif
    issue(3'd5, 2'd0, 2'd0, 2'd1, 4'b0011);
`ifdef ALU_ISSUE_FLAGS_EN
    check("plan.flag_z", flag_z, 1'b0);
`endif

    // Host load colliding with writeback: same address loses, other address lands.
    load(2'd0, 4'b0110);
    load(2'd1, 4'b0011);
    for (int j = 0; j < 2; j++) begin
      set_instr(3'd2, 2'd2, 2'd0, 2'd1);
      instr_valid = 1;
      tick("coll.accept");
      instr_valid = 0;
      ld_en = 1; ld_addr = (j == 0) ? 2'd2 : 2'd3; ld_data = 4'b1010;
      tick("coll.wb");
      ld_en = 0;
      peek(2'd2, 4'b0101);
      if (j == 1) peek(2'd3, 4'b1010);
    end

    // Reset during EXEC of an add into r1.
    set_instr(3'd5, 2'd1, 2'd0, 2'd0);
    instr_valid = 1;
    tick("rst.accept");
    instr_valid = 0;
    reset = 1;
    model_reset();
    #1;
    check_all("rst.async");
    @(posedge clk);
    #1;
    check_all("rst.hold");
    reset = 0;
    tick("rst.release");
    check("rst.ready", instr_ready, 1'b1);
    check("rst.no_valid", result_valid, 1'b0);
    peek(2'd1, 4'b0000);

    // Random traffic, including loads on accept and writeback edges.
    for (int n = 0; n < 400; n++) begin
      instr_valid = ($urandom_range(0, 2) != 0);
      set_instr(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      ld_en    = ($urandom_range(0, 2) == 0);
      ld_addr  = 2'($urandom);
      ld_data  = 4'($urandom);
      dbg_addr = 2'($urandom);
      tick("rand");
    end
    ld_en = 0;
    instr_valid = 0;
    tick("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
